if_id_stage: RTL
================

// Module: if_id_stage
// PURPOSE
//  Fetch stage plus IF/ID pipeline register of the 5-stage MIPS redirect pipeline.
//  Holds the PC and drives the word address of the asynchronous-read instruction ROM.
//  Latches the fetched word into the IR that feeds the controller/decoder in ID.
//  Applies load-use stalls, branch/jump redirects (flush) and the halt from syscall.
// PARAMETERS
//  PC_RESET  32'h0000_3000  PC value loaded on reset
//  IMEM_AW   10             instruction ROM word-address width (1K words)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  imem_addr    out  IMEM_AW  ROM word address = pc[IMEM_AW+1:2], combinational from pc
//  imem_data    in   32       ROM read data, valid in the same cycle as imem_addr
//  stall        in   1        hold pc and IF/ID contents (load-use hazard from hazard unit)
//  redirect     in   1        taken branch/jump resolved downstream; squash IF/ID
//  redirect_pc  in   32       target PC, valid when redirect=1
//  halt         in   1        one-cycle pulse, syscall retired
//  id_ir        out  32       instruction to ID (controller IR input)
//  id_pc        out  32       PC of id_ir
//  id_pc4       out  32       id_pc + 4 (link value for jal/jalr)
//  id_valid     out  1        id_ir holds a real instruction (0 = bubble)
//  halted       out  1        stage is in HALT
// BEHAVIOUR
//  Reset (async, immediate): pc=PC_RESET, id_ir=32'h0, id_pc=0, id_pc4=0, id_valid=0,
//    halted=0, FSM=RUN. Reset mid-operation discards all in-flight state.
//  FSM: RUN -> HALT on halt=1. HALT is left only by rst.
//  Per-edge priority in RUN: halt > redirect > stall > normal.
//   normal: id_ir<=imem_data; id_pc<=pc; id_pc4<=pc+4; id_valid<=1; pc<=pc+4.
//   stall:  pc and all id_* hold their values.
//   redirect (including while stall=1): pc<={redirect_pc[31:2],2'b00};
//     id_ir<=32'h0 (sll $0,$0,0); id_valid<=0; id_pc/id_pc4 hold.
//   halt: go to HALT; id_ir<=0; id_valid<=0; pc holds.
//  HALT: pc frozen; id_ir=0 and id_valid=0 every cycle; halted=1;
//    stall/redirect/halt are ignored.
//  Latency: the word at pc reaches id_ir one edge later. Redirect costs one bubble.
//  Arithmetic: pc+4 is a 32-bit modulo add; 32'hFFFF_FFFC wraps to 0.
//    imem_addr uses the truncated pc bits, so the ROM address wraps at 2^IMEM_AW words.
//  pc[1:0] is always 2'b00.
// CONFIGURATION
//  Macro IF_PERF_CNT_EN. When defined, the block adds two outputs:
//   fetch_cnt   out 32   +1 per normal-advance edge
//   bubble_cnt  out 32   +1 per redirect or stall edge taken in RUN
//  Both counters reset to 0, wrap modulo 2^32 and freeze in HALT.
//  When not defined, the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  mips_pkg (shared) holds:
//   NOP_INSTR=32'h0, PC_RESET_DEF, state encoding IF_RUN=1'b0 / IF_HALT=1'b1,
//   opcode/funct constants reused by the controller and hazard unit.
//  Sub-module if_id_reg: id_ir/id_pc/id_pc4/id_valid register with en (=~stall) and
//   flush (=redirect|halt) inputs; flush has priority over en.
//  pc register, next-pc mux and FSM stay in if_id_stage.
// TESTING
//  1. Reset, ROM[0]=32'h2008_0005, 3 free edges -> id_pc = 3000,3004,3008;
//     id_ir=32'h2008_0005 after edge 1; id_valid=1.
//  2. stall=1 for 2 cycles at pc=300C -> pc, id_ir, id_pc unchanged;
//     advance resumes at 300C on release.
//  3. redirect=1 with redirect_pc=32'h0000_3043 -> next edge: pc=3040, id_ir=0, id_valid=0;
//     following edge: id_pc=3040.
//  4. redirect=1 and stall=1 together -> redirect wins (pc=target, bubble);
//     halt with redirect -> HALT, pc unchanged.
//  5. halt pulse -> halted=1, id_valid=0 forever; pulse redirect -> no change;
//     assert rst mid-cycle -> outputs at reset values before the next edge.
//  6. IF_PERF_CNT_EN: 5 advances + 1 stall + 1 redirect -> fetch_cnt=5, bubble_cnt=2;
//     rebuild without the macro -> test 1 passes unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the 5-stage MIPS redirect pipeline
//
// Purpose: constants shared by the fetch stage, controller and hazard unit.
//   NOP_INSTR     encoding of sll $0,$0,0 used for pipeline bubbles
//   PC_RESET_DEF  default reset PC
//   if_state_e    fetch-stage FSM encoding (IF_RUN / IF_HALT)
//   OP_* / FN_*   opcode and funct fields decoded downstream
package mips_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

  typedef enum logic {
    IF_RUN  = 1'b0,
    IF_HALT = 1'b1
  } if_state_e;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  // Sequential successor of a word-aligned PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with enable and flush
//
// Purpose: holds the instruction handed to ID together with its PC and PC+4.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   en_i             load ir_i/pc_i/pc4_i and mark valid (stall = ~en_i)
//   flush_i          squash: ir <= NOP, valid <= 0, pc/pc4 hold; beats en_i
//   ir_i, pc_i, pc4_i  fetched word, its PC and PC+4
//   ir_o, pc_o, pc4_o, valid_o  registered IF/ID contents
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] ir_q, pc_q, pc4_q;
  logic        valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q    <= NOP_INSTR;
      pc_q    <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      // pc/pc4 keep the squashed slot's last values; only ir/valid matter to ID
      ir_q    <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (en_i) begin
      ir_q    <= ir_i;
      pc_q    <= pc_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign ir_o    = ir_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - fetch stage, PC register and IF/ID register of the MIPS pipeline
//
// Purpose: holds the PC, addresses the async instruction ROM, latches the fetched
//   word into IF/ID, and applies stall, redirect (flush) and syscall halt.
// Optional feature: macro IF_PERF_CNT_EN adds fetch_cnt / bubble_cnt counters.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_addr                ROM word address (pc[IMEM_AW+1:2])
//   imem_data                ROM read data, same cycle
//   stall                    hold pc and IF/ID
//   redirect, redirect_pc    taken branch/jump target; squashes IF/ID
//   halt                     syscall retired; enter HALT until reset
//   id_ir, id_pc, id_pc4     instruction to ID, its PC and PC+4
//   id_valid                 id_ir is a real instruction
//   halted                   stage is in HALT
//   fetch_cnt, bubble_cnt    (IF_PERF_CNT_EN only) advance / bubble edge counts
module if_id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic [31:0]        id_ir,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic               id_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        bubble_cnt,
`endif
  output logic               halted
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4;
  logic        run;
  logic        advance;
  logic        bubble;
  logic        reg_en;
  logic        reg_flush;

  assign run = (state_q == IF_RUN);
  assign pc4 = pc_plus4(pc_q);

  // Edge classification in RUN, priority halt > redirect > stall > normal
  assign advance = run && !halt && !redirect && !stall;
  assign bubble  = run && !halt && (redirect || stall);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (run) begin
      if (halt) begin
        state_d = IF_HALT;
      end else if (redirect) begin
        pc_d = {redirect_pc[31:2], 2'b00};
      end else if (!stall) begin
        pc_d = pc4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IF_RUN;
      pc_q    <= {PC_RESET[31:2], 2'b00};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // In HALT the register is flushed every edge so id_ir/id_valid stay at NOP/0
  // regardless of what the ignored stall/redirect/halt inputs do.
  assign reg_en    = run && !stall;
  assign reg_flush = !run || redirect || halt;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .en_i    (reg_en),
    .flush_i (reg_flush),
    .ir_i    (imem_data),
    .pc_i    (pc_q),
    .pc4_i   (pc4),
    .ir_o    (id_ir),
    .pc_o    (id_pc),
    .pc4_o   (id_pc4),
    .valid_o (id_valid)
  );

  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign halted    = !run;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if (advance) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (bubble)  bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = advance ^ bubble;
`endif

endmodule
